// File: rtl/serial_bit_sampler.sv
// Synchronises an external SPI-mode-0 style link into clk_i and feeds a shift register.
// Optional glitch filter on sck/cs_n: define SERIAL_BIT_SAMPLER_GLITCH_FILTER_EN.
module serial_bit_sampler #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          COVER       = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sck_i,
  input  logic                     sdi_i,
  input  logic                     cs_n_i,
  output logic                     advance_o,
  output logic                     bit_o,
  output logic                     clear_o,
  output logic                     frame_done_o,
  output logic                     frame_abort_o,
  output logic [$clog2(WIDTH)-1:0] bit_count_o,
  output logic                     busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_n_sync_q;
  logic                   sck_raw, sdi_raw, cs_n_raw;
  logic                   sck_s, sdi_s, cs_n_s;
  logic                   sck_prev_q, cs_n_prev_q;
  logic                   rise, cs_fall;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   advance_q, advance_d;
  logic                   bit_q, bit_d;
  logic                   wrap_q, wrap_d;
  logic                   done_q;
  logic                   abort_q, abort_d;
  logic                   clear;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      cs_n_sync_q <= '1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_i};
    end
  end

  assign sck_raw  = sck_sync_q[SYNC_STAGES-1];
  assign sdi_raw  = sdi_sync_q[SYNC_STAGES-1];
  assign cs_n_raw = cs_n_sync_q[SYNC_STAGES-1];

`ifdef SERIAL_BIT_SAMPLER_GLITCH_FILTER_EN
  // The filtered level follows the raw level only once it has been seen on three
  // consecutive cycles; sdi is delayed to stay aligned with the filtered sck.
  logic [1:0] sck_hist_q, cs_n_hist_q, sdi_dly_q;
  logic       sck_filt_q, cs_n_filt_q;

  assign sck_s  = (sck_raw == sck_hist_q[0] && sck_raw == sck_hist_q[1]) ? sck_raw : sck_filt_q;
  assign cs_n_s = (cs_n_raw == cs_n_hist_q[0] && cs_n_raw == cs_n_hist_q[1]) ? cs_n_raw
                                                                               : cs_n_filt_q;
  assign sdi_s  = sdi_dly_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_hist_q  <= 2'b00;
      cs_n_hist_q <= 2'b11;
      sdi_dly_q   <= 2'b00;
      sck_filt_q  <= 1'b0;
      cs_n_filt_q <= 1'b1;
    end else begin
      sck_hist_q  <= {sck_hist_q[0], sck_raw};
      cs_n_hist_q <= {cs_n_hist_q[0], cs_n_raw};
      sdi_dly_q   <= {sdi_dly_q[0], sdi_raw};
      sck_filt_q  <= sck_s;
      cs_n_filt_q <= cs_n_s;
    end
  end
`else
  assign sck_s  = sck_raw;
  assign cs_n_s = cs_n_raw;
  assign sdi_s  = sdi_raw;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sck_prev_q  <= sck_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  assign rise    = sck_s & ~sck_prev_q;
  assign cs_fall = cs_n_prev_q & ~cs_n_s;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    advance_d = 1'b0;
    bit_d     = 1'b0;
    wrap_d    = 1'b0;
    abort_d   = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          clear   = 1'b1;
          count_d = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        // Chip-select release takes priority over a coincident sck rise.
        if (cs_n_s) begin
          state_d = StIdle;
          abort_d = (count_q != '0);
          count_d = '0;
        end else if (rise) begin
          advance_d = 1'b1;
          bit_d     = sdi_s;
          if (count_q == CntW'(WIDTH - 1)) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      advance_q <= 1'b0;
      bit_q     <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      advance_q <= advance_d;
      bit_q     <= bit_d;
      wrap_q    <= wrap_d;
      done_q    <= wrap_q;
      abort_q   <= abort_d;
    end
  end

  assign advance_o     = advance_q;
  assign bit_o         = bit_q;
  assign clear_o       = clear;
  assign frame_done_o  = done_q;
  assign frame_abort_o = abort_q;
  assign bit_count_o   = count_q;
  assign busy_o        = (state_q == StActive);

  if (COVER) begin : g_cover
`ifdef FORMAL
    cover property (@(posedge clk_i) disable iff (rst_i) frame_done_o);
    cover property (@(posedge clk_i) disable iff (rst_i) frame_abort_o);
`endif
  end

endmodule

// File: tb/tb_serial_bit_sampler.sv
// Directed bench for serial_bit_sampler: frames, latency, abort, back-to-back, reset, glitch.
module tb_serial_bit_sampler;

`ifdef SERIAL_BIT_SAMPLER_GLITCH_FILTER_EN
  localparam int Extra = 2;
`else
  localparam int Extra = 0;
`endif
  localparam int AdvLat = 3 + Extra;  // posedges after the one preceding the sck change
  localparam int ClrLat = 2 + Extra;  // posedges after the reset edge

  logic       clk = 1'b0;
  logic       rst, sck, sdi, cs_n;
  logic       advance, bit_v, clear, done, abort, busy;
  logic [2:0] bit_count;

  serial_bit_sampler #(.WIDTH(8), .SYNC_STAGES(2), .COVER(1'b0)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sck_i        (sck),
    .sdi_i        (sdi),
    .cs_n_i       (cs_n),
    .advance_o    (advance),
    .bit_o        (bit_v),
    .clear_o      (clear),
    .frame_done_o (done),
    .frame_abort_o(abort),
    .bit_count_o  (bit_count),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Event monitor plus a model of the downstream shift register.
  int         cyc = 0, n_adv = 0, n_done = 0, n_abort = 0, n_clear = 0, n_consec = 0;
  logic       adv_prev = 1'b0;
  logic [7:0] model = 8'h00;
  int         adv_bits[$], adv_cnt[$], adv_cyc[$], done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (clear) begin
      n_clear++;
      model = 8'h00;
    end
    if (advance) begin
      n_adv++;
      adv_bits.push_back(int'(bit_v));
      adv_cnt.push_back(int'(bit_count));
      adv_cyc.push_back(cyc);
      model = {model[6:0], bit_v};
      if (adv_prev) n_consec++;
    end
    adv_prev = advance;
    if (done) begin
      n_done++;
      done_cyc.push_back(cyc);
    end
    if (abort) n_abort++;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // MSB first, sck period 8 clk_i cycles, sdi changes while sck is low.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = v[7-i];
      sck = 1'b0;
      tick(4);
      sck = 1'b1;
      tick(4);
    end
    sck = 1'b0;
    tick(4);
  endtask

  int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int a0, b0, d0, c0, r0;

  initial begin
    rst = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    tick(3);
    chk("rst_advance", advance, 0);
    chk("rst_bit", bit_v, 0);
    chk("rst_clear", clear, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_count", bit_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(4);

    // Single 0xA5 frame.
    a0 = n_adv; b0 = adv_bits.size(); d0 = n_done; c0 = n_clear; r0 = n_abort;
    cs_n = 1'b0;
    tick(8);
    send_bits(8'hA5, 8);
    tick(4);
    chk("a5_adv_cnt", n_adv - a0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("a5_bit", adv_bits[b0+i], exp_a5[i]);
      chk("a5_count", adv_cnt[b0+i], (i + 1) % 8);
    end
    chk("a5_done_cnt", n_done - d0, 1);
    chk("a5_done_lag", done_cyc[d0] - adv_cyc[b0+7], 1);
    chk("a5_value", model, 8'hA5);
    chk("a5_busy", busy, 1);
    cs_n = 1'b1;
    tick(8);
    chk("a5_clear_cnt", n_clear - c0, 1);
    chk("a5_no_abort", n_abort - r0, 0);
    chk("a5_busy_low", busy, 0);

    // Latency of a single sck rise.
    cs_n = 1'b0;
    tick(8);
    r0 = n_abort;
    sck = 1'b1;
    for (int i = 1; i <= AdvLat; i++) begin
      tick(1);
      chk("lat_advance", advance, (i == AdvLat) ? 1 : 0);
    end
    tick(4);
    sck = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(8);
    chk("lat_abort", n_abort - r0, 1);

    // Abort after three bits.
    a0 = n_adv; d0 = n_done; r0 = n_abort;
    cs_n = 1'b0;
    tick(8);
    send_bits(8'hE0, 3);
    chk("abort_busy_high", busy, 1);
    chk("abort_count", bit_count, 3);
    cs_n = 1'b1;
    tick(8);
    chk("abort_adv_cnt", n_adv - a0, 3);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_cnt", n_abort - r0, 1);
    chk("abort_busy_low", busy, 0);

    // Back-to-back words in one chip-select assertion.
    a0 = n_adv; d0 = n_done; c0 = n_clear; r0 = n_abort;
    cs_n = 1'b0;
    tick(8);
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    tick(4);
    chk("b2b_value", model, 8'h3C);
    cs_n = 1'b1;
    tick(8);
    chk("b2b_adv_cnt", n_adv - a0, 16);
    chk("b2b_done_cnt", n_done - d0, 2);
    chk("b2b_clear_cnt", n_clear - c0, 1);
    chk("b2b_no_abort", n_abort - r0, 0);

    // Reset mid-word with cs_n held low.
    cs_n = 1'b0;
    tick(8);
    send_bits(8'hFF, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_advance", advance, 0);
    chk("mrst_bit", bit_v, 0);
    chk("mrst_done", done, 0);
    chk("mrst_abort", abort, 0);
    chk("mrst_count", bit_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_clear_early", clear, 0);
    for (int i = 1; i <= ClrLat; i++) begin
      tick(1);
      chk("mrst_clear", clear, (i == ClrLat) ? 1 : 0);
    end
    d0 = n_done;
    tick(4);
    chk("mrst_busy_high", busy, 1);
    send_bits(8'h96, 8);
    tick(4);
    chk("mrst_value", model, 8'h96);
    chk("mrst_done_cnt", n_done - d0, 1);
    cs_n = 1'b1;
    tick(8);

    // One-cycle sck glitch.
    cs_n = 1'b0;
    tick(8);
    a0 = n_adv;
    sck = 1'b1;
    tick(1);
    sck = 1'b0;
    tick(10);
    chk("glitch_adv_cnt", n_adv - a0, (Extra != 0) ? 0 : 1);
    cs_n = 1'b1;
    tick(8);

    chk("no_consec_advance", n_consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
